apb_cmd_master: RTL

- Upstream stage of the timer IP: converts a simple valid/ready command stream from the host or test sequencer into APB transactions on the timer's tim_* slave port.
- Buffers commands in a small FIFO and runs one APB transfer at a time (IDLE/SETUP/ACCESS/RESP).
- Returns read data and error status on a valid/ready response channel.
- A programmable wait-state timeout guards against a slave that never asserts pready.

---
 rtl/apb_cmd_master_if.sv | 44 ++++
 rtl/apb_cmd_master.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apb_cmd_master_if.sv
// Bundles the command, response and APB slave-port signals of apb_cmd_master.
// master: the command master itself; slave: its environment (host side plus timer APB port).
interface apb_cmd_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tmo;

  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic        tim_pready;
  logic        tim_pslverr;
  logic [31:0] tim_prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    input  rsp_ready,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_pready, tim_pslverr, tim_prdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    output rsp_ready,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_pready, tim_pslverr, tim_prdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Command-stream to APB master for the timer IP: buffers valid/ready commands in a FIFO,
// runs one APB transfer at a time and returns data/error (or a wait-state timeout).
module apb_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  apb_cmd_master_if.master bus,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] wait_cnt;
  state_t        state;
  cmd_t          head;
  logic          full;
  logic          push;
  logic          pop;

  assign full          = (count == (AW+1)'(FIFO_DEPTH));
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;
  assign pop           = (state == IDLE) && (count != '0) && !bus.rsp_valid;
  assign head          = mem[rd_ptr];
  assign busy          = (count != '0) || (state != IDLE);

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by count,
  // so stale entries are never read and the array can map onto plain RAM/flops without reset.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{write: bus.req_write, addr: bus.req_addr,
                       wdata: bus.req_wdata, strb: bus.req_strb};
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of statement order across and within always_ff blocks.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.tim_psel    <= 1'b0;
      bus.tim_penable <= 1'b0;
      bus.tim_pwrite  <= 1'b0;
      bus.tim_paddr   <= '0;
      bus.tim_pwdata  <= '0;
      bus.tim_pstrb   <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_tmo     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state          <= SETUP;
            bus.tim_psel   <= 1'b1;
            bus.tim_pwrite <= head.write;
            bus.tim_paddr  <= head.addr;
            // Reads present all-zero data and strobes on the bus.
            bus.tim_pwdata <= head.write ? head.wdata : '0;
            bus.tim_pstrb  <= head.write ? head.strb  : '0;
          end
        end
        SETUP: begin
          state           <= ACCESS;
          bus.tim_penable <= 1'b1;
          wait_cnt        <= '0;
        end
        ACCESS: begin
          // pready is checked first so a late slave still wins over the abort.
          if (bus.tim_pready) begin
            state           <= RESP;
            bus.tim_psel    <= 1'b0;
            bus.tim_penable <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= bus.tim_pwrite ? '0 : bus.tim_prdata;
            bus.rsp_err     <= bus.tim_pslverr;
            bus.rsp_tmo     <= 1'b0;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state           <= RESP;
            bus.tim_psel    <= 1'b0;
            bus.tim_penable <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_tmo     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
